// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion path: digit width, converter
// state encoding and the digit-count helper used by elaboration checks.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Decimal digits needed to represent the largest unsigned WIDTH-bit value.
    function automatic int min_digits(input int width);
        longint unsigned max_val;
        int              d;
        max_val = (64'd1 << width) - 64'd1;
        d = 0;
        for (int i = 0; i < 20; i++) begin
            if (max_val != 64'd0) begin
                max_val = max_val / 64'd10;
                d = d + 1;
            end
        end
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/addthree.sv
// Double-dabble correction cell: a BCD digit of 5..9 gets +3 before the shift.
// Digit values 10..15 are not legal BCD and collapse to 0.
module addthree (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = 4'd0;
        case (din)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: dout = din;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: dout = din + 4'd3;
            default:                      dout = 4'd0;
        endcase
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with a start/busy/done handshake and a result register holding the last value.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("bin2bcd_seq: WIDTH must be in 4..32");
    end
    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] bin_sr_reg, bin_sr_next;
    logic [ACC_W-1:0] acc_reg,    acc_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [ACC_W-1:0] bcd_reg,    bcd_next;
    logic             done_reg,   done_next;

    logic [ACC_W-1:0] acc_corr;
    logic [ACC_W-1:0] acc_shift;

    // One correction cell per digit, applied to the accumulator before each shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
        addthree u_addthree (
            .din  (acc_reg [gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (acc_corr[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign acc_shift = {acc_corr[ACC_W-2:0], bin_sr_reg[WIDTH-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            bin_sr_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            bcd_reg    <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            bin_sr_reg <= bin_sr_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            bcd_reg    <= bcd_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        bin_sr_next = bin_sr_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        bcd_next    = bcd_reg;
        done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    bin_sr_next = bin;
                    acc_next    = '0;
                    cnt_next    = CNT_INIT;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                acc_next    = acc_shift;
                bin_sr_next = {bin_sr_reg[WIDTH-2:0], 1'b0};
                cnt_next    = cnt_reg - CNT_ONE;
                // Final shift: publish the uncorrected post-shift accumulator.
                if (cnt_reg == CNT_ONE) begin
                    bcd_next   = acc_shift;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg == SHIFT);
    assign done = done_reg;
    assign bcd  = bcd_reg;

endmodule
